// File: rtl/bmi_speed_calc.sv
// Computes integer BMI from a captured height/weight pair with a restoring divider,
// then maps it linearly onto a clamped motor speed level.
module bmi_speed_calc #(
   parameter int unsigned BMI_MIN    = 15,
   parameter int unsigned BMI_MAX    = 30,
   parameter int unsigned SPEED_MIN  = 1,
   parameter int unsigned SPEED_MAX  = 10,
   parameter int unsigned HEIGHT_MIN = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] in_height,
   input  logic [6:0] in_weight,
   output logic       busy,
   output logic       result_valid,
   output logic [5:0] bmi,
   output logic [3:0] speed_level,
   output logic       bmi_sat,
   output logic       input_err
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_MAP  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [7:0] MAP_DEN = 8'(BMI_MAX - BMI_MIN);

   logic [2:0]  state;
   logic [7:0]  height;
   logic [6:0]  weight;
   logic [20:0] num;
   logic [15:0] den;
   logic [15:0] rem;
   logic [4:0]  cnt;
   logic [5:0]  bmi_int;
   logic        sat_int;
   logic        clamp_lo;
   logic        clamp_hi;
   logic [7:0]  mnum;
   logic [7:0]  mrem;

   logic [16:0] div_shift, div_diff;
   logic        div_ge;
   logic [20:0] quot_n;
   logic        sat_n, lo_n, hi_n;
   logic [5:0]  bmi_n;
   logic [31:0] bmi_w, prod;
   logic [8:0]  map_shift, map_diff;
   logic        map_ge;
   logic [7:0]  mq_n;
   logic [3:0]  speed_n;

   assign busy = (state != ST_IDLE);

   always_comb begin
      // Numerator shifts out MSB first while quotient bits shift in at the LSB.
      div_shift = {rem, num[20]};
      div_diff  = div_shift - {1'b0, den};
      div_ge    = (div_shift >= {1'b0, den});
      quot_n    = {num[19:0], div_ge};
      sat_n     = |quot_n[20:6];
      bmi_n     = sat_n ? 6'd63 : quot_n[5:0];
      bmi_w     = {26'd0, bmi_n};
      lo_n      = (bmi_w <= BMI_MIN);
      hi_n      = (bmi_w >= BMI_MAX);
      prod      = (bmi_w - BMI_MIN) * (SPEED_MAX - SPEED_MIN);

      map_shift = {mrem, mnum[7]};
      map_diff  = map_shift - {1'b0, MAP_DEN};
      map_ge    = (map_shift >= {1'b0, MAP_DEN});
      mq_n      = {mnum[6:0], map_ge};
      if (clamp_lo)      speed_n = 4'(SPEED_MIN);
      else if (clamp_hi) speed_n = 4'(SPEED_MAX);
      else               speed_n = 4'(SPEED_MIN) + mq_n[3:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         height       <= '0;
         weight       <= '0;
         num          <= '0;
         den          <= '0;
         rem          <= '0;
         cnt          <= '0;
         bmi_int      <= '0;
         sat_int      <= 1'b0;
         clamp_lo     <= 1'b0;
         clamp_hi     <= 1'b0;
         mnum         <= '0;
         mrem         <= '0;
         result_valid <= 1'b0;
         bmi          <= '0;
         speed_level  <= '0;
         bmi_sat      <= 1'b0;
         input_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               result_valid <= 1'b0;
               if (start) begin
                  height <= in_height;
                  weight <= in_weight;
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               num <= 21'(weight) * 21'd10000;
               den <= {8'd0, height} * {8'd0, height};
               rem <= '0;
               if (height < 8'(HEIGHT_MIN)) begin
                  input_err    <= 1'b1;
                  bmi          <= '0;
                  speed_level  <= '0;
                  bmi_sat      <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= ST_DONE;
               end else begin
                  cnt   <= 5'd21;
                  state <= ST_DIV;
               end
            end
            ST_DIV: begin
               num <= quot_n;
               rem <= div_ge ? div_diff[15:0] : div_shift[15:0];
               cnt <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  // Clamped cases still run the full map loop on a zero numerator.
                  bmi_int  <= bmi_n;
                  sat_int  <= sat_n;
                  clamp_lo <= lo_n;
                  clamp_hi <= hi_n;
                  mnum     <= (lo_n || hi_n) ? 8'd0 : prod[7:0];
                  mrem     <= '0;
                  cnt      <= 5'd8;
                  state    <= ST_MAP;
               end
            end
            ST_MAP: begin
               mnum <= mq_n;
               mrem <= map_ge ? map_diff[7:0] : map_shift[7:0];
               cnt  <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  bmi          <= bmi_int;
                  bmi_sat      <= sat_int;
                  input_err    <= 1'b0;
                  speed_level  <= speed_n;
                  result_valid <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               result_valid <= 1'b0;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bmi_speed_calc.sv
// Scoreboard bench for bmi_speed_calc: driver queues expected results, a negedge monitor
// pops and compares whenever result_valid is seen.
module tb_bmi_speed_calc;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] in_height;
   logic [6:0] in_weight;
   logic       busy, result_valid, bmi_sat, input_err;
   logic [5:0] bmi;
   logic [3:0] speed_level;

   typedef struct {
      int bmi;
      int spd;
      int sat;
      int err;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   bmi_speed_calc dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_height    (in_height),
      .in_weight    (in_weight),
      .busy         (busy),
      .result_valid (result_valid),
      .bmi          (bmi),
      .speed_level  (speed_level),
      .bmi_sat      (bmi_sat),
      .input_err    (input_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("bmi", int'(bmi), mon_e.bmi);
            chk("speed_level", int'(speed_level), mon_e.spd);
            chk("bmi_sat", int'(bmi_sat), mon_e.sat);
            chk("input_err", int'(input_err), mon_e.err);
            chk("latency", cyc, mon_e.cyc);
         end
      end
   end

   // Called at a negedge; returns at the negedge after edge 0 with start low.
   task automatic issue(input int h, input int w, input int eb, input int es,
                        input int esat, input int eerr);
      exp_t e;
      in_height = 8'(h);
      in_weight = 7'(w);
      start     = 1'b1;
      e.bmi = eb;
      e.spd = es;
      e.sat = esat;
      e.err = eerr;
      e.cyc = cyc + 1 + (eerr != 0 ? 1 : 30);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int eb);
      int n = 0;
      int busy_bad = 0;
      while (result_valid !== 1'b1 && n < 40) begin
         if (busy !== 1'b1) busy_bad = 1;
         @(negedge clk);
         n++;
      end
      chk("busy_during_run", busy_bad, 0);
      chk("valid_seen", int'(result_valid === 1'b1), 1);
      chk("busy_in_done", int'(busy), 1);
      @(negedge clk);
      chk("valid_one_cycle", int'(result_valid), 0);
      chk("busy_after_done", int'(busy), 0);
      chk("bmi_hold", int'(bmi), eb);
   endtask

   task automatic run(input int h, input int w, input int eb, input int es,
                      input int esat, input int eerr);
      issue(h, w, eb, es, esat, eerr);
      wait_done(eb);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      in_height = '0;
      in_weight = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_bmi", int'(bmi), 0);
      chk("rst_speed", int'(speed_level), 0);
      chk("rst_sat", int'(bmi_sat), 0);
      chk("rst_err", int'(input_err), 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed vectors: h, w, bmi, speed, sat, err
      run(175, 70,  22, 5,  0, 0);
      run(160, 90,  35, 10, 0, 0);
      run(200, 40,  10, 1,  0, 0);
      run(100, 15,  15, 1,  0, 0);
      run(100, 30,  30, 10, 0, 0);
      run(100, 20,  20, 4,  0, 0);
      run(100, 25,  25, 7,  0, 0);
      run(100, 127, 63, 10, 1, 0);
      run(0,   70,  0,  0,  0, 1);
      run(49,  70,  0,  0,  0, 1);
      run(50,  10,  40, 10, 0, 0);
      run(170, 0,   0,  1,  0, 0);

      // Restart attempt and input change mid-run must be ignored.
      issue(175, 70, 22, 5, 0, 0);
      repeat (9) @(negedge clk);
      start     = 1'b1;
      in_height = 8'd100;
      in_weight = 7'd127;
      @(negedge clk);
      start = 1'b0;
      wait_done(22);
      repeat (35) @(negedge clk);

      // Reset in the middle of a division.
      in_height = 8'd160;
      in_weight = 7'd90;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_valid", int'(result_valid), 0);
      chk("mid_rst_bmi", int'(bmi), 0);
      chk("mid_rst_speed", int'(speed_level), 0);
      chk("mid_rst_sat", int'(bmi_sat), 0);
      chk("mid_rst_err", int'(input_err), 0);
      reset = 1'b0;
      @(negedge clk);
      run(160, 90, 35, 10, 0, 0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
